// File: rtl/datamem_responder.sv
// Load/store responder on a little-endian byte array with programmable wait states.
// Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept cycle; one request in flight.
// Backpressure: RESP holds with stable outputs until rsp_ready; req_ready only while IDLE.
// Optional: define DATAMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses via rsp_err.
module datamem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_BYTES     = 4096,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int IDXW = $clog2(MEM_BYTES);
  localparam int CW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic                    cap_we;
  logic [IDXW-1:0]         cap_idx;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  logic [1:0]              cap_size;
  logic                    cap_uns;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic [7:0]              mem [MEM_BYTES];

  logic                    accept;
  logic                    do_access;
  logic                    wr_en;
  logic                    a_we;
  logic [IDXW-1:0]         a_raw;
  logic [IDXW-1:0]         a_idx;
  logic [DATA_WIDTH-1:0]   a_wdata;
  logic [1:0]              a_size;
  logic                    a_uns;
  logic                    a_mis;
  logic [7:0]              rb0, rb1, rb2, rb3;
  logic [DATA_WIDTH-1:0]   ld_data;
  logic                    unused_addr;

  // Address bits above the array size wrap away.
  assign unused_addr = ^req_addr[ADDRESS_WIDTH-1:IDXW];

  assign accept    = (state_q == S_IDLE) && req_valid;
  // With zero wait states the access happens on the accepting edge itself.
  assign do_access = (accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == CW'(WAIT_CYCLES)));
  assign wr_en     = do_access && a_we && !a_mis && rst_n;

  // Access operands: live request on the accepting edge, captured copy afterwards.
  always_comb begin
    a_we    = cap_we;
    a_raw   = cap_idx;
    a_wdata = cap_wdata;
    a_size  = cap_size;
    a_uns   = cap_uns;
    if (state_q == S_IDLE) begin
      a_we    = req_we;
      a_raw   = req_addr[IDXW-1:0];
      a_wdata = req_wdata;
      a_size  = req_size;
      a_uns   = req_unsigned;
    end
    case (a_size)
      2'd0:    a_idx = a_raw;
      2'd1:    a_idx = {a_raw[IDXW-1:1], 1'b0};
      default: a_idx = {a_raw[IDXW-1:2], 2'b00};
    endcase
`ifdef DATAMEM_MISALIGN_ERR_EN
    a_mis = ((a_size == 2'd1) && a_raw[0]) || (a_size[1] && (a_raw[1:0] != 2'b00));
`else
    a_mis = 1'b0;
`endif
  end

  // Little-endian read of up to four bytes, then size/sign extension.
  always_comb begin
    rb0 = mem[a_idx];
    rb1 = mem[a_idx + IDXW'(1)];
    rb2 = mem[a_idx + IDXW'(2)];
    rb3 = mem[a_idx + IDXW'(3)];
    case (a_size)
      2'd0:    ld_data = a_uns ? {24'b0, rb0} : {{24{rb0[7]}}, rb0};
      2'd1:    ld_data = a_uns ? {16'b0, rb1, rb0} : {{16{rb1[7]}}, rb1, rb0};
      default: ld_data = {rb3, rb2, rb1, rb0};
    endcase
  end

  // Byte array writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[a_idx] <= a_wdata[7:0];
      if (a_size != 2'd0) begin
        mem[a_idx + IDXW'(1)] <= a_wdata[15:8];
      end
      if (a_size[1]) begin
        mem[a_idx + IDXW'(2)] <= a_wdata[23:16];
        mem[a_idx + IDXW'(3)] <= a_wdata[31:24];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (do_access) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, wait counter and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_size  <= 2'd0;
      cap_uns   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_idx   <= req_addr[IDXW-1:0];
        cap_wdata <= req_wdata;
        cap_size  <= req_size;
        cap_uns   <= req_unsigned;
        cnt_q     <= CW'(1);
      end else if (state_q == S_WAIT) begin
        cnt_q <= do_access ? '0 : cnt_q + CW'(1);
      end
      if (do_access) begin
        rdata_q <= (a_we || a_mis) ? '0 : ld_data;
        err_q   <= a_mis;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_datamem_responder.sv
module tb_datamem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  int          passed = 0;
  int          total  = 0;

  // Instance A: default build, two wait states.
  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [1:0]  a_req_size;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;

  // Instance B: zero wait states.
  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [1:0]  b_req_size;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;

  always #5 clk = ~clk;

  datamem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_BYTES(4096), .WAIT_CYCLES(2)) ua (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_size(a_req_size),
    .req_unsigned(a_req_unsigned), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  datamem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_BYTES(4096), .WAIT_CYCLES(0)) ub (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
    .req_unsigned(b_req_unsigned), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

`ifdef DATAMEM_MISALIGN_ERR_EN
  localparam logic MIS_ERR = 1'b1;
`else
  localparam logic MIS_ERR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One request on A, starting and ending at a negedge. Checks latency,
  // busy window, response data/error and the return of req_ready.
  task automatic a_txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int   n;
    logic busy_ok;
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
    a_req_wdata = wdata; a_req_size = size; a_req_unsigned = uns;
    busy_ok = a_req_ready;
    @(posedge clk); @(negedge clk);
    a_req_valid = 1'b0; a_req_we = ~we; a_req_addr = ~addr;
    a_req_wdata = ~wdata; a_req_size = ~size; a_req_unsigned = ~uns;
    n = 1;
    while (!a_rsp_valid && n < 20) begin
      if (a_req_ready) busy_ok = 1'b0;
      @(negedge clk); n++;
    end
    if (a_req_ready) busy_ok = 1'b0;
    check({tag, " latency"}, n, 3);
    check({tag, " busy"}, {31'b0, busy_ok}, 1);
    check({tag, " rdata"}, a_rsp_rdata, exp_rdata);
    check({tag, " err"}, {31'b0, a_rsp_err}, {31'b0, exp_err});
    a_rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a_rsp_ready = 1'b0;
    check({tag, " ready/valid after handshake"}, {30'b0, a_req_ready, a_rsp_valid}, 32'h2);
  endtask

  // One request on B with rsp_ready held high, for back-to-back operation.
  task automatic b_txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
    b_req_wdata = wdata; b_req_size = size; b_req_unsigned = uns;
    check({tag, " ready at accept"}, {31'b0, b_req_ready}, 1);
    @(posedge clk); @(negedge clk);
    b_req_valid = 1'b0; b_req_addr = ~addr;
    check({tag, " valid next cycle"}, {30'b0, b_req_ready, b_rsp_valid}, 32'h1);
    check({tag, " rdata"}, b_rsp_rdata, exp_rdata);
    @(posedge clk); @(negedge clk);
    check({tag, " ready after handshake"}, {30'b0, b_req_ready, b_rsp_valid}, 32'h2);
  endtask

  initial begin
    logic [31:0] held;
    logic        bp_ok;
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    a_req_size = 2'd0; a_req_unsigned = 1'b0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_req_size = 2'd0; b_req_unsigned = 1'b0; b_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("reset ready", {31'b0, a_req_ready}, 1);
    check("reset valid", {31'b0, a_rsp_valid}, 0);
    check("reset rdata", a_rsp_rdata, 0);
    check("reset err", {31'b0, a_rsp_err}, 0);

    a_txn("st word 0x10",  1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 1'b0);
    a_txn("ld word 0x10",  1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    a_txn("ld byte s 0x13", 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 32'hFFFFFFDE, 1'b0);
    a_txn("ld byte u 0x13", 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 32'h000000DE, 1'b0);
    a_txn("ld half s 0x10", 1'b0, 32'h10, 32'h0, 2'd1, 1'b0, 32'hFFFFBEEF, 1'b0);
    a_txn("ld half u 0x12", 1'b0, 32'h12, 32'h0, 2'd1, 1'b1, 32'h0000DEAD, 1'b0);
    a_txn("st byte 0x11",  1'b1, 32'h11, 32'hFFFFFF55, 2'd0, 1'b0, 32'h0, 1'b0);
    a_txn("ld word after byte", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEAD55EF, 1'b0);
    a_txn("ld size3 0x10", 1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 32'hDEAD55EF, 1'b0);
    a_txn("ld half s 0x11", 1'b0, 32'h11, 32'h0, 2'd1, 1'b0,
          MIS_ERR ? 32'h0 : 32'h000055EF, MIS_ERR);
    a_txn("st wrap 0x1004", 1'b1, 32'h00001004, 32'h12345678, 2'd2, 1'b0, 32'h0, 1'b0);
    a_txn("ld wrap 0x4",   1'b0, 32'h4, 32'h0, 2'd2, 1'b0, 32'h12345678, 1'b0);
    a_txn("st word 0x20",  1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0, 32'h0, 1'b0);
    a_txn("st word 0x21",  1'b1, 32'h21, 32'hAAAAAAAA, 2'd2, 1'b0, 32'h0, MIS_ERR);
    a_txn("ld word 0x20",  1'b0, 32'h20, 32'h0, 2'd2, 1'b0,
          MIS_ERR ? 32'h11223344 : 32'hAAAAAAAA, 1'b0);

    // Back-pressure: hold RESP five cycles while a store is offered.
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10; a_req_size = 2'd2;
    @(posedge clk); @(negedge clk);
    a_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    held  = 32'hDEAD55EF;
    bp_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10 + 32'(i);
      a_req_wdata = 32'(i); a_req_size = 2'(i);
      if (!a_rsp_valid || a_req_ready || a_rsp_rdata !== held) bp_ok = 1'b0;
      @(negedge clk);
    end
    check("backpressure hold", {31'b0, bp_ok}, 1);
    check("backpressure rdata", a_rsp_rdata, held);
    a_req_valid = 1'b0; a_rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a_rsp_ready = 1'b0;
    check("backpressure release", {30'b0, a_req_ready, a_rsp_valid}, 32'h2);
    bp_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (a_rsp_valid) bp_ok = 1'b0;
    end
    check("single response only", {31'b0, bp_ok}, 1);
    a_txn("ld after backpressure", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEAD55EF, 1'b0);

    // Reset while a store sits in WAIT: store is dropped.
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10;
    a_req_wdata = 32'hCAFEF00D; a_req_size = 2'd2;
    @(posedge clk); @(negedge clk);
    a_req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("midreset ready/valid", {30'b0, a_req_ready, a_rsp_valid}, 32'h2);
    check("midreset rdata", a_rsp_rdata, 0);
    bp_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (a_rsp_valid) bp_ok = 1'b0;
    end
    check("midreset no response", {31'b0, bp_ok}, 1);
    a_txn("ld after midreset", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEAD55EF, 1'b0);

    // Zero-wait instance, back-to-back.
    b_txn("b st word 0x8", 1'b1, 32'h8, 32'h0BADF00D, 2'd2, 1'b0, 32'h0);
    b_txn("b ld word 0x8", 1'b0, 32'h8, 32'h0, 2'd2, 1'b0, 32'h0BADF00D);
    b_txn("b ld byte s 0x9", 1'b0, 32'h9, 32'h0, 2'd0, 1'b0, 32'hFFFFFFF0);
    b_txn("b ld half u 0xA", 1'b0, 32'hA, 32'h0, 2'd1, 1'b1, 32'h00000BAD);
    check("b err", {31'b0, b_rsp_err}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
